eth_rx_frame: RTL and testbench

//  Ethernet receive framer, directly downstream of the 100Mb PHY adapter RX byte port.
//  - Strips preamble/SFD, checks FCS (CRC-32), enforces length limits.
//  - Emits a byte stream with start/end/error markers to the MAC/SR2CB layer.

---
 rtl/eth_pkg.sv | 19 +
 rtl/crc32_d8.sv | 22 ++
 rtl/eth_rx_frame.sv | 172 +++++++++++++++++
 tb/tb_eth_rx_frame.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: framing bytes, CRC-32 constants and
// the receive framer state type.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        DROP,
        IDLE,
        PRE,
        DATA
    } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 byte step (reflected polynomial, LSB of the byte
// first). Holds no state, so a transmit framer can reuse it directly.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [7:0]  d,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Eight serial LFSR steps unrolled into one byte-wide update.
    always_comb begin
        c = crc_in;
        for (int unsigned i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ (CRC32_POLY & {32{c[0] ^ d[i]}});
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_rx_frame.sv
// Ethernet receive framer: strips preamble/SFD, checks the FCS, enforces
// frame length limits and emits a byte stream with sof/eof/err markers.
// Build option ETH_RX_FCS_STRIP_EN: when defined the four FCS bytes are held
// back and never emitted (5-entry holding buffer); otherwise every received
// byte is emitted through a single holding register.
module eth_rx_frame
    import eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_d,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  m_d,
    output logic        m_dv,
    output logic        m_sof,
    output logic        m_eof,
    output logic        m_err,
    output logic [10:0] m_len
);

`ifdef ETH_RX_FCS_STRIP_EN
    localparam int unsigned HOLD = 5;
`else
    localparam int unsigned HOLD = 1;
`endif
    localparam int unsigned OLD = HOLD - 1;

    rx_state_t   state_q, state_d;
    logic [31:0] crc_q, crc_nx;
    logic [10:0] len_q;
    logic        sticky_q;
    logic        emitted_q;
    logic [7:0]  hold_q [HOLD];
    logic [2:0]  fill_q;
    logic        full;

    logic        start, push, close, ovf;

    logic [7:0]  beat_d;
    logic        beat_dv, beat_sof, beat_eof, beat_err;
    logic [10:0] beat_len;

    crc32_d8 u_crc (
        .d       (rx_d),
        .crc_in  (crc_q),
        .crc_out (crc_nx)
    );

    assign full = (fill_q == 3'(HOLD));

    // State register; reset parks in DROP so a frame already in flight is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DROP;
        else        state_q <= state_d;
    end

    // Next state plus per-byte control strobes.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        push    = 1'b0;
        close   = 1'b0;
        ovf     = 1'b0;
        case (state_q)
            DROP: if (!rx_dv) state_d = IDLE;
            IDLE: if (rx_dv) state_d = (rx_d == ETH_PREAMBLE) ? PRE : DROP;
            PRE: begin
                if (!rx_dv) begin
                    state_d = IDLE;
                end else if (rx_d == ETH_SFD) begin
                    state_d = DATA;
                    start   = 1'b1;
                end else if (rx_d != ETH_PREAMBLE) begin
                    state_d = DROP;
                end
            end
            DATA: begin
                if (!rx_dv) begin
                    close   = 1'b1;
                    state_d = IDLE;
                end else if (len_q == 11'(MAX_FRAME)) begin
                    // This byte would exceed the limit: close now, discard it.
                    close   = 1'b1;
                    ovf     = 1'b1;
                    state_d = DROP;
                end else begin
                    push    = 1'b1;
                end
            end
            default: state_d = DROP;
        endcase
    end

    // Output beat: oldest held byte leaves when a new byte pushes it out, or on close.
    always_comb begin
        beat_dv  = 1'b0;
        beat_d   = '0;
        beat_sof = 1'b0;
        beat_eof = 1'b0;
        beat_err = 1'b0;
        beat_len = '0;
        if (push && full) begin
            beat_dv  = 1'b1;
            beat_d   = hold_q[OLD];
            beat_sof = !emitted_q;
        end
        if (close) begin
            beat_dv  = 1'b1;
            beat_eof = 1'b1;
            beat_len = ovf ? len_q + 11'd1 : len_q;
            beat_err = ovf | (crc_q != CRC32_RESIDUE) | sticky_q | (len_q < 11'(MIN_FRAME));
            if (full) begin
                beat_d   = hold_q[OLD];
                beat_sof = !emitted_q;
            end else begin
                // Nothing left to carry the end marker: emit a bare abort beat.
                beat_sof = 1'b1;
                beat_err = 1'b1;
            end
        end
    end

    // Frame datapath: CRC, length, sticky PHY error and the byte holding buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q     <= CRC32_INIT;
            len_q     <= '0;
            sticky_q  <= 1'b0;
            emitted_q <= 1'b0;
            fill_q    <= '0;
            for (int unsigned i = 0; i < HOLD; i++) hold_q[i] <= '0;
        end else if (start) begin
            crc_q     <= CRC32_INIT;
            len_q     <= '0;
            sticky_q  <= 1'b0;
            emitted_q <= 1'b0;
            fill_q    <= '0;
        end else if (push) begin
            crc_q     <= crc_nx;
            len_q     <= len_q + 11'd1;
            sticky_q  <= sticky_q | rx_er;
            hold_q[0] <= rx_d;
            for (int unsigned i = 1; i < HOLD; i++) hold_q[i] <= hold_q[i-1];
            if (!full) fill_q    <= fill_q + 3'd1;
            else       emitted_q <= 1'b1;
        end
    end

    // Registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d   <= '0;
            m_dv  <= 1'b0;
            m_sof <= 1'b0;
            m_eof <= 1'b0;
            m_err <= 1'b0;
            m_len <= '0;
        end else begin
            m_d   <= beat_d;
            m_dv  <= beat_dv;
            m_sof <= beat_sof;
            m_eof <= beat_eof;
            m_err <= beat_err;
            m_len <= beat_len;
        end
    end

endmodule

// File: tb/tb_eth_rx_frame.sv
// Bench for eth_rx_frame: two instances (roomy and tight MAX_FRAME) share one
// stimulus stream; each output beat stream is compared against a frame-level
// reference model.
module tb_eth_rx_frame;

    localparam int MINF = 13;
    localparam int MAXA = 80;
    localparam int MAXB = 20;
`ifdef ETH_RX_FCS_STRIP_EN
    localparam int TAIL = 4;   // FCS bytes withheld from the stream
`else
    localparam int TAIL = 0;
`endif

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [7:0]  d;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] len;
    } beat_t;
    typedef beat_t bt_q [$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_d;
    logic        rx_dv, rx_er;
    logic [7:0]  m_d_a, m_d_b;
    logic        m_dv_a, m_sof_a, m_eof_a, m_err_a;
    logic        m_dv_b, m_sof_b, m_eof_b, m_err_b;
    logic [10:0] m_len_a, m_len_b;

    int checks   = 0;
    int failures = 0;

    bt_q got_a, got_b, exp_a, exp_b;

    always #5 clk = ~clk;

    eth_rx_frame #(.MIN_FRAME(MINF), .MAX_FRAME(MAXA)) dut_a (
        .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_dv(rx_dv), .rx_er(rx_er),
        .m_d(m_d_a), .m_dv(m_dv_a), .m_sof(m_sof_a), .m_eof(m_eof_a),
        .m_err(m_err_a), .m_len(m_len_a)
    );

    eth_rx_frame #(.MIN_FRAME(MINF), .MAX_FRAME(MAXB)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_dv(rx_dv), .rx_er(rx_er),
        .m_d(m_d_b), .m_dv(m_dv_b), .m_sof(m_sof_b), .m_eof(m_eof_b),
        .m_err(m_err_b), .m_len(m_len_b)
    );

    // Collect every output beat, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t ba, bb;
        if (m_dv_a) begin
            ba.d = m_d_a; ba.sof = m_sof_a; ba.eof = m_eof_a; ba.err = m_err_a; ba.len = m_len_a;
            got_a.push_back(ba);
        end
        if (m_dv_b) begin
            bb.d = m_d_b; bb.sof = m_sof_b; bb.eof = m_eof_b; bb.err = m_err_b; bb.len = m_len_b;
            got_b.push_back(bb);
        end
    end

    // Standard Ethernet CRC-32 of the first n bytes (byte-wise software form).
    function automatic logic [31:0] crc32(bq_t p, int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, p[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t with_fcs(bq_t p);
        bq_t r = p;
        logic [31:0] c = crc32(p, p.size());
        r.push_back(c[7:0]);  r.push_back(c[15:8]);
        r.push_back(c[23:16]); r.push_back(c[31:24]);
        return r;
    endfunction

    function automatic bit fcs_ok(bq_t f);
        int n = f.size();
        if (n < 4) return 1'b0;
        return {f[n-1], f[n-2], f[n-3], f[n-4]} == crc32(f, n - 4);
    endfunction

    // Expected beats for one frame: accepted bytes minus withheld FCS, eof on
    // the last emitted one; an abort beat when there is nothing to emit.
    function automatic bt_q model(bq_t f, bit had_er, int maxf);
        bt_q r;
        beat_t b;
        int n = f.size();
        int avail, seen, last;
        logic err;
        if (n > maxf) begin
            avail = maxf; seen = maxf + 1; err = 1'b1;
        end else begin
            avail = n; seen = n; err = had_er | (n < MINF) | !fcs_ok(f);
        end
        last = avail - TAIL - 1;
        if (last < 0) begin
            b.d = 8'h00; b.sof = 1'b1; b.eof = 1'b1; b.err = 1'b1; b.len = 11'(seen);
            r.push_back(b);
        end else begin
            for (int i = 0; i <= last; i++) begin
                b.d = f[i]; b.sof = (i == 0); b.eof = (i == last);
                b.err = err; b.len = 11'(seen);
                r.push_back(b);
            end
        end
        return r;
    endfunction

    // Compared fields; err/len only carry meaning on the eof beat.
    function automatic logic [21:0] bv(beat_t b);
        return {b.d, b.sof, b.eof, b.eof ? b.err : 1'b0, b.eof ? b.len : 11'd0};
    endfunction

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(negedge clk);
        rx_d = d; rx_dv = dv; rx_er = er;
    endtask

    task automatic gap(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_raw(input bq_t bytes);
        foreach (bytes[i]) drive(bytes[i], 1'b1, 1'b0);
    endtask

    task automatic send_frame(input bq_t f, input int npre, input int er_idx, input int gapn);
        bt_q t;
        bit had_er = (er_idx >= 0) && (er_idx < f.size());
        repeat (npre) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        foreach (f[i]) drive(f[i], 1'b1, (i == er_idx));
        gap(gapn);
        t = model(f, had_er, MAXA);
        foreach (t[i]) exp_a.push_back(t[i]);
        t = model(f, had_er, MAXB);
        foreach (t[i]) exp_b.push_back(t[i]);
    endtask

    task automatic check_q(input string tag, input string which, input bt_q got, input bt_q exp);
        int n = (got.size() < exp.size()) ? got.size() : exp.size();
        checks++;
        assert (got.size() === exp.size()) else begin
            failures++;
            $error("FAIL %s.%s beat_count got=%0d exp=%0d", tag, which, got.size(), exp.size());
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (bv(got[i]) === bv(exp[i])) else begin
                failures++;
                $error("FAIL %s.%s beat%0d {d,sof,eof,err,len} got=%h/%b%b%b/%0d exp=%h/%b%b%b/%0d",
                       tag, which, i, got[i].d, got[i].sof, got[i].eof, got[i].eof & got[i].err,
                       got[i].eof ? got[i].len : 11'd0, exp[i].d, exp[i].sof, exp[i].eof,
                       exp[i].eof & exp[i].err, exp[i].eof ? exp[i].len : 11'd0);
            end
        end
    endtask

    task automatic drain(input string tag);
        gap(4);
        check_q(tag, "A", got_a, exp_a);
        check_q(tag, "B", got_b, exp_b);
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({m_dv_a, m_sof_a, m_eof_a, m_err_a, m_d_a, m_len_a} === 23'd0) else begin
            failures++;
            $error("FAIL %s.A outputs got=%h exp=0", tag, {m_dv_a, m_sof_a, m_eof_a, m_err_a, m_d_a, m_len_a});
        end
        checks++;
        assert ({m_dv_b, m_sof_b, m_eof_b, m_err_b, m_d_b, m_len_b} === 23'd0) else begin
            failures++;
            $error("FAIL %s.B outputs got=%h exp=0", tag, {m_dv_b, m_sof_b, m_eof_b, m_err_b, m_d_b, m_len_b});
        end
    endtask

    initial begin
        bq_t p, f;
        rst_n = 1'b0; rx_d = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
        #3;
        check_zero("reset_init");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gap(2);
        check_zero("after_reset");

        // Known-answer frame: "123456789" + FCS 26 39 F4 CB.
        p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(f, 7, -1, 3);
        drain("good_kat");

        // Corrupted last FCS byte.
        f[12] = 8'hCA;
        send_frame(f, 7, -1, 3);
        drain("bad_fcs");

        // 64-byte valid frame with a PHY error on byte 20.
        p.delete();
        for (int i = 0; i < 60; i++) p.push_back(8'($urandom));
        send_frame(with_fcs(p), 7, 19, 3);
        drain("rx_er");

        // Broken preamble, 1-clk gap, then a good frame.
        send_raw('{8'h55, 8'h55, 8'hAA});
        gap(1);
        send_frame(with_fcs('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}), 7, -1, 3);
        drain("bad_pre");

        // Back-to-back frames separated by a single idle clock.
        p.delete();
        for (int i = 0; i < 12; i++) p.push_back(8'($urandom));
        send_frame(with_fcs(p), 7, -1, 1);
        send_frame(with_fcs(p), 2, -1, 1);
        drain("b2b");

        // 30 data bytes: overlength for the MAX_FRAME=20 instance.
        p.delete();
        for (int i = 0; i < 30; i++) p.push_back(8'($urandom));
        send_frame(p, 7, -1, 2);
        drain("overlen");

        // Runt, single-byte and empty frames.
        send_frame('{8'h11, 8'h22, 8'h33}, 7, -1, 2);
        drain("runt3");
        send_frame('{8'hA5}, 3, -1, 2);
        drain("one_byte");
        p.delete();
        send_frame(p, 1, -1, 2);
        drain("empty");

        // Randomized frames.
        for (int k = 0; k < 14; k++) begin
            int n;
            int er;
            p.delete();
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(5, 36);
                for (int i = 0; i < n; i++) p.push_back(8'($urandom));
                f = with_fcs(p);
            end else begin
                n = $urandom_range(0, 40);
                f.delete();
                for (int i = 0; i < n; i++) f.push_back(8'($urandom));
            end
            er = (f.size() > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, f.size() - 1) : -1;
            send_frame(f, $urandom_range(1, 8), er, $urandom_range(1, 3));
            drain($sformatf("rand%0d", k));
        end

        // Reset in the middle of a frame.
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) drive(8'(i + 1), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        assert ({m_dv_a, m_dv_b} === 2'b11) else begin
            failures++;
            $error("FAIL mid_frame_dv got=%b exp=11", {m_dv_a, m_dv_b});
        end
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        got_a.delete(); got_b.delete();
        drive(8'h40, 1'b1, 1'b0);
        rst_n = 1'b1;
        send_raw('{8'h41, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07});
        gap(2);
        drain("dv_held_after_reset");
        send_frame(with_fcs('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}), 7, -1, 3);
        drain("after_reset_frame");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
